// File: rtl/lc3_control.sv
// LC-3 microsequencer: fetch/decode/execute FSM driving datapath controls and the memory handshake.
// Optional JSR/JSRR support is compiled in when the LC3_JSR_EN macro is defined.
module lc3_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        memRDY,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        enaALU,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        flagWE,
  output logic        regWE,
  output logic        memEN,
  output logic        memWE,
  output logic [1:0]  selPC,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        selMARM,
  output logic [2:0]  DR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [1:0]  ALUctrl,
  output logic        halted,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_ALU, S_BR, S_JMP, S_LEA,
    S_LD_ADDR, S_LD_MEM, S_LD_WB,
    S_ST_ADDR, S_ST_DATA, S_ST_MEM,
    S_JSR, S_HALT
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          cur, nxt;
  logic [CW-1:0]   wait_cnt;
  logic            waiting;
  logic            timed_out;
  logic [3:0]      opcode;

  assign opcode  = IR[15:12];
  assign state   = cur;
  assign waiting = (cur == S_FETCH1) || (cur == S_LD_MEM) || (cur == S_ST_MEM);

  // The limit cycle itself still honours memRDY; only a low memRDY there halts.
  assign timed_out = (MEM_TIMEOUT > 0) && !memRDY && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_RESET;
      wait_cnt <= '0;
    end else begin
      cur <= nxt;
      if (waiting && !memRDY) wait_cnt <= wait_cnt + 1'b1;
      else                    wait_cnt <= '0;
    end
  end

  // NOTE: every always_comb assigns defaults first so no path can infer a latch.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_RESET:   nxt = S_FETCH0;
      S_FETCH0:  nxt = S_FETCH1;
      S_FETCH1:  if (memRDY) nxt = S_FETCH2; else if (timed_out) nxt = S_HALT;
      S_FETCH2:  nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'b0001, 4'b0101, 4'b1001: nxt = S_ALU;
          4'b0000:                   nxt = S_BR;
          4'b1100:                   nxt = S_JMP;
          4'b1110:                   nxt = S_LEA;
          4'b0010, 4'b0110:          nxt = S_LD_ADDR;
          4'b0011, 4'b0111:          nxt = S_ST_ADDR;
`ifdef LC3_JSR_EN
          4'b0100:                   nxt = S_JSR;
`endif
          default:                   nxt = S_HALT;
        endcase
      end
      S_ALU, S_BR, S_JMP, S_LEA, S_LD_WB, S_JSR: nxt = S_FETCH0;
      S_LD_ADDR: nxt = S_LD_MEM;
      S_LD_MEM:  if (memRDY) nxt = S_LD_WB; else if (timed_out) nxt = S_HALT;
      S_ST_ADDR: nxt = S_ST_DATA;
      S_ST_DATA: nxt = S_ST_MEM;
      S_ST_MEM:  if (memRDY) nxt = S_FETCH0; else if (timed_out) nxt = S_HALT;
      default:   nxt = S_HALT;
    endcase
  end

  always_comb begin
    enaMARM = 1'b0; enaPC  = 1'b0; enaMDR = 1'b0; enaALU = 1'b0;
    ldPC    = 1'b0; ldIR   = 1'b0; ldMAR  = 1'b0; ldMDR  = 1'b0;
    selMDR  = 1'b0; flagWE = 1'b0; regWE  = 1'b0;
    memEN   = 1'b0; memWE  = 1'b0;
    selPC   = 2'd0; selEAB1 = 1'b0; selEAB2 = 2'd0; selMARM = 1'b0;
    DR      = 3'd0; SR1    = 3'd0; ALUctrl = 2'd0; halted = 1'b0;
    SR2     = IR[2:0];

    case (cur)
      S_FETCH0: begin
        enaPC = 1'b1; ldMAR = 1'b1; ldPC = 1'b1;
      end
      S_FETCH1, S_LD_MEM: begin
        memEN = 1'b1; selMDR = 1'b1; ldMDR = memRDY;
      end
      S_FETCH2: begin
        enaMDR = 1'b1; ldIR = 1'b1;
      end
      S_ALU: begin
        DR = IR[11:9]; SR1 = IR[8:6];
        enaALU = 1'b1; regWE = 1'b1; flagWE = 1'b1;
        case (opcode)
          4'b0001: ALUctrl = 2'd1;
          4'b0101: ALUctrl = 2'd2;
          default: ALUctrl = 2'd3;
        endcase
      end
      S_BR: begin
        if ((IR[11] & N) | (IR[10] & Z) | (IR[9] & P)) begin
          ldPC = 1'b1; selPC = 2'd1; selEAB2 = 2'd2;
        end
      end
      S_JMP: begin
        SR1 = IR[8:6]; selEAB1 = 1'b1; selPC = 2'd1; ldPC = 1'b1;
      end
      S_LEA: begin
        selEAB2 = 2'd2; selMARM = 1'b1; enaMARM = 1'b1;
        DR = IR[11:9]; regWE = 1'b1; flagWE = 1'b1;
      end
      S_LD_ADDR, S_ST_ADDR: begin
        selMARM = 1'b1; enaMARM = 1'b1; ldMAR = 1'b1;
        // IR[14] separates the base+offset6 forms (LDR/STR) from PC-relative LD/ST.
        if (IR[14]) begin
          selEAB1 = 1'b1; SR1 = IR[8:6]; selEAB2 = 2'd1;
        end else begin
          selEAB2 = 2'd2;
        end
      end
      S_LD_WB: begin
        enaMDR = 1'b1; DR = IR[11:9]; regWE = 1'b1; flagWE = 1'b1;
      end
      S_ST_DATA: begin
        SR1 = IR[11:9]; enaALU = 1'b1; ldMDR = 1'b1;
      end
      S_ST_MEM: begin
        memEN = 1'b1; memWE = 1'b1;
      end
`ifdef LC3_JSR_EN
      S_JSR: begin
        DR = 3'd7; enaPC = 1'b1; regWE = 1'b1; ldPC = 1'b1; selPC = 2'd1;
        if (IR[11]) begin
          selEAB2 = 2'd3;
        end else begin
          selEAB1 = 1'b1; SR1 = IR[8:6];
        end
      end
`endif
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control.sv
// Randomised instruction stream against a phase-sequence model of the LC-3 microsequencer.
module tb_lc3_control;

  localparam int TMO = 8;

  typedef struct packed {
    logic       enaMARM, enaPC, enaMDR, enaALU;
    logic       ldPC, ldIR, ldMAR, ldMDR;
    logic       selMDR, flagWE, regWE, memEN, memWE;
    logic [1:0] selPC;
    logic       selEAB1;
    logic [1:0] selEAB2;
    logic       selMARM;
    logic [2:0] DR, SR1, SR2;
    logic [1:0] ALUctrl;
    logic       halted;
  } ctl_t;

  typedef enum {
    P_RESET, P_FETCH0, P_FETCH1, P_FETCH2, P_DECODE, P_ALU, P_BR, P_JMP, P_LEA,
    P_LD_ADDR, P_LD_MEM, P_LD_WB, P_ST_ADDR, P_ST_DATA, P_ST_MEM, P_JSR, P_HALT
  } phase_t;

  logic        clk, rst;
  logic [15:0] IR;
  logic        N, Z, P, memRDY;
  logic        enaMARM, enaPC, enaMDR, enaALU, ldPC, ldIR, ldMAR, ldMDR;
  logic        selMDR, flagWE, regWE, memEN, memWE, selEAB1, selMARM, halted;
  logic [1:0]  selPC, selEAB2, ALUctrl;
  logic [2:0]  DR, SR1, SR2;
  logic [4:0]  state;
  ctl_t        got;

  int n_checks = 0;
  int n_pass   = 0;

  lc3_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .IR(IR), .N(N), .Z(Z), .P(P), .memRDY(memRDY),
    .enaMARM(enaMARM), .enaPC(enaPC), .enaMDR(enaMDR), .enaALU(enaALU),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .selMDR(selMDR), .flagWE(flagWE), .regWE(regWE),
    .memEN(memEN), .memWE(memWE), .selPC(selPC), .selEAB1(selEAB1),
    .selEAB2(selEAB2), .selMARM(selMARM), .DR(DR), .SR1(SR1), .SR2(SR2),
    .ALUctrl(ALUctrl), .halted(halted), .state(state)
  );

  assign got = {enaMARM, enaPC, enaMDR, enaALU, ldPC, ldIR, ldMAR, ldMDR,
                selMDR, flagWE, regWE, memEN, memWE, selPC, selEAB1, selEAB2,
                selMARM, DR, SR1, SR2, ALUctrl, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s ir=%h got=%h expected=%h", tag, IR, obs, exp);
  endtask

  // Expected control word for one cycle of a named execution phase.
  function automatic ctl_t model(input phase_t ph, input logic [15:0] ir,
                                 input logic n, input logic z, input logic p,
                                 input logic rdy);
    ctl_t c;
    c = '0;
    c.SR2 = ir[2:0];
    case (ph)
      P_FETCH0: begin c.enaPC = 1; c.ldMAR = 1; c.ldPC = 1; end
      P_FETCH1, P_LD_MEM: begin c.memEN = 1; c.selMDR = 1; c.ldMDR = rdy; end
      P_FETCH2: begin c.enaMDR = 1; c.ldIR = 1; end
      P_ALU: begin
        c.DR = ir[11:9]; c.SR1 = ir[8:6];
        c.enaALU = 1; c.regWE = 1; c.flagWE = 1;
        c.ALUctrl = (ir[15:12] == 4'h1) ? 2'd1 : (ir[15:12] == 4'h5) ? 2'd2 : 2'd3;
      end
      P_BR: if ((ir[11] && n) || (ir[10] && z) || (ir[9] && p)) begin
        c.ldPC = 1; c.selPC = 2'd1; c.selEAB2 = 2'd2;
      end
      P_JMP: begin c.SR1 = ir[8:6]; c.selEAB1 = 1; c.selPC = 2'd1; c.ldPC = 1; end
      P_LEA: begin
        c.selEAB2 = 2'd2; c.selMARM = 1; c.enaMARM = 1;
        c.DR = ir[11:9]; c.regWE = 1; c.flagWE = 1;
      end
      P_LD_ADDR, P_ST_ADDR: begin
        c.selMARM = 1; c.enaMARM = 1; c.ldMAR = 1;
        if (ir[15:12] == 4'h6 || ir[15:12] == 4'h7) begin
          c.selEAB1 = 1; c.SR1 = ir[8:6]; c.selEAB2 = 2'd1;
        end else c.selEAB2 = 2'd2;
      end
      P_LD_WB: begin c.enaMDR = 1; c.DR = ir[11:9]; c.regWE = 1; c.flagWE = 1; end
      P_ST_DATA: begin c.SR1 = ir[11:9]; c.enaALU = 1; c.ldMDR = 1; end
      P_ST_MEM: begin c.memEN = 1; c.memWE = 1; end
      P_JSR: begin
        c.DR = 3'd7; c.enaPC = 1; c.regWE = 1; c.ldPC = 1; c.selPC = 2'd1;
        if (ir[11]) c.selEAB2 = 2'd3;
        else begin c.selEAB1 = 1; c.SR1 = ir[8:6]; end
      end
      P_HALT: c.halted = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Called just after a rising edge: drive memRDY, compare mid-cycle, advance one clock.
  task automatic cyc(input phase_t ph, input logic rdy);
    memRDY = rdy;
    @(negedge clk);
    check(ph.name(), got, model(ph, IR, N, Z, P, rdy));
    @(posedge clk);
    #1;
  endtask

  // Holds rst for n edges; returns with the FSM in FETCH0 for the current cycle.
  task automatic do_reset(input int n);
    rst = 1'b1;
    memRDY = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 1; i < n; i++) cyc(P_RESET, rb());
    rst = 1'b0;
    cyc(P_RESET, rb());
  endtask

  task automatic mem_wait(input phase_t ph, input int lat);
    for (int i = 0; i < lat; i++) cyc(ph, 1'b0);
    cyc(ph, 1'b1);
  endtask

  // One full instruction starting in FETCH0; illegal opcodes end in HALT plus a reset.
  task automatic run_instr(input logic [15:0] ir, input logic [2:0] nzp,
                           input int lat_f, input int lat_m);
    IR = ir;
    {N, Z, P} = nzp;
    cyc(P_FETCH0, rb());
    mem_wait(P_FETCH1, lat_f);
    cyc(P_FETCH2, rb());
    cyc(P_DECODE, rb());
    case (ir[15:12])
      4'h1, 4'h5, 4'h9: cyc(P_ALU, rb());
      4'h0: cyc(P_BR, rb());
      4'hC: cyc(P_JMP, rb());
      4'hE: cyc(P_LEA, rb());
      4'h2, 4'h6: begin
        cyc(P_LD_ADDR, rb());
        mem_wait(P_LD_MEM, lat_m);
        cyc(P_LD_WB, rb());
      end
      4'h3, 4'h7: begin
        cyc(P_ST_ADDR, rb());
        cyc(P_ST_DATA, rb());
        mem_wait(P_ST_MEM, lat_m);
      end
`ifdef LC3_JSR_EN
      4'h4: cyc(P_JSR, rb());
`endif
      default: begin
        for (int i = 0; i < 3; i++) cyc(P_HALT, rb());
        do_reset(1);
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; IR = '0; N = 0; Z = 0; P = 0; memRDY = 0;

    do_reset(2);
    run_instr(16'h1042, 3'b000, 0, 0);
    run_instr(16'h0405, 3'b010, 0, 0);
    run_instr(16'h0405, 3'b100, 0, 0);
    run_instr(16'h6283, 3'b000, 0, 3);
    run_instr(16'h5A7F, 3'b001, TMO - 1, 0);
    run_instr(16'hD000, 3'b000, 0, 0);
    run_instr(16'h4801, 3'b000, 0, 0);
    run_instr(16'h4080, 3'b000, 1, 0);

    // Store that never completes: exactly TMO wait cycles, then HALT until reset.
    IR = 16'h3A05;
    cyc(P_FETCH0, rb());
    mem_wait(P_FETCH1, 0);
    cyc(P_FETCH2, rb());
    cyc(P_DECODE, rb());
    cyc(P_ST_ADDR, rb());
    cyc(P_ST_DATA, rb());
    for (int i = 0; i < TMO; i++) cyc(P_ST_MEM, 1'b0);
    for (int i = 0; i < 4; i++) cyc(P_HALT, rb());
    do_reset(1);

    // Reset arriving while a load is still waiting on memory.
    IR = 16'h6283;
    cyc(P_FETCH0, rb());
    mem_wait(P_FETCH1, 0);
    cyc(P_FETCH2, rb());
    cyc(P_DECODE, rb());
    cyc(P_LD_ADDR, rb());
    for (int i = 0; i < 3; i++) cyc(P_LD_MEM, 1'b0);
    do_reset(1);

    for (int k = 0; k < 80; k++)
      run_instr(16'($urandom), 3'($urandom), $urandom_range(0, TMO - 1),
                $urandom_range(0, TMO - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lc3_control.md
Name: lc3_control

Overview:
Microsequencer FSM for the LC-3 core. It sits directly upstream of the LC-3 datapath and drives every datapath enable, load, mux-select and register-address line. It decodes IR and the N/Z/P flags and handshakes with memory through memEN/memWE/memRDY. It covers fetch, decode and execute for ADD, AND, NOT, BR, JMP, LD, LDR, LEA, ST and STR, and halts on illegal opcodes or memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for memRDY before HALT; 0 = wait forever.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
IR  input  16  instruction register contents from datapath
N, Z, P  input  1 each  condition flags from datapath
memRDY  input  1  memory access complete this cycle
enaMARM, enaPC, enaMDR, enaALU  output  1 each  bus tri-state enables (one-hot or none)
ldPC, ldIR, ldMAR, ldMDR  output  1 each  register loads
selMDR  output  1  1 = MDR from memory, 0 = MDR from bus
flagWE, regWE  output  1 each  NZP write / register-file write
memEN, memWE  output  1 each  memory request / write qualifier
selPC  output  2  0 = PC+1, 1 = eabOut, 2 = Buss
selEAB1  output  1  0 = PC, 1 = Ra
selEAB2  output  2  0 = zero, 1 = sext off6, 2 = sext off9, 3 = sext off11
selMARM  output  1  0 = zext IR[7:0], 1 = eabOut
DR, SR1, SR2  output  3 each  register addresses
ALUctrl  output  2  0 = pass A, 1 = ADD, 2 = AND, 3 = NOT
halted  output  1  FSM in HALT
state  output  5  current state encoding, for debug and assertions

Behaviour:
- Moore outputs, decoded from the registered state, plus IR fields. Any output not listed for a state is 0. SR2 is always IR[2:0].
- rst high at an edge -> state RESET. RESET: all outputs 0. RESET always goes to FETCH0 on the next edge. rst has priority in every state, including mid-memory-wait.
- FETCH0: enaPC, ldMAR, ldPC, selPC=0.
- FETCH1: memEN, selMDR=1. ldMDR=memRDY. Holds until memRDY, then FETCH2.
- FETCH2: enaMDR, ldIR. Then DECODE.
- DECODE: no outputs. Branches on IR[15:12].
- ADD(0001)/AND(0101)/NOT(1001) -> ALU:
  - ALU: DR=IR[11:9], SR1=IR[8:6], ALUctrl=1/2/3, enaALU, regWE, flagWE.
- BR(0000) -> BR:
  - BR: if (IR[11]&N)|(IR[10]&Z)|(IR[9]&P) then ldPC, selPC=1, selEAB1=0, selEAB2=2; otherwise nothing.
- JMP(1100) -> JMP:
  - JMP: SR1=IR[8:6], selEAB1=1, selEAB2=0, selPC=1, ldPC.
- LEA(1110) -> LEA:
  - LEA: selEAB1=0, selEAB2=2, selMARM=1, enaMARM, DR=IR[11:9], regWE, flagWE.
- LD(0010)/LDR(0110) -> LD_ADDR:
  - LD_ADDR: selMARM=1, enaMARM, ldMAR. LD uses selEAB1=0, selEAB2=2. LDR uses selEAB1=1, SR1=IR[8:6], selEAB2=1.
  - LD_MEM: as FETCH1; on memRDY -> LD_WB.
  - LD_WB: enaMDR, DR=IR[11:9], regWE, flagWE.
- ST(0011)/STR(0111) -> ST_ADDR:
  - ST_ADDR: same as LD_ADDR, with the ST/STR address selects.
  - ST_DATA: SR1=IR[11:9], ALUctrl=0, enaALU, ldMDR, selMDR=0.
  - ST_MEM: memEN, memWE. Holds until memRDY.
- All terminal execute states return to FETCH0.
- Instruction timing with memRDY in the first wait cycle:
  - ALU/BR/JMP/LEA: 5 cycles.
  - LD/LDR: 7 cycles.
  - ST/STR: 7 cycles.
- Any other opcode -> HALT. HALT: halted=1, all other outputs 0, exits only on rst.
- Timeout:
  - Counter cleared on entry to FETCH1, LD_MEM or ST_MEM.
  - Increments each wait cycle without memRDY.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with memRDY still low -> HALT.
  - memRDY on the same cycle as the limit wins; normal progress.
- At most one bus enable is high in any state.

Optional Feature:
Macro LC3_JSR_EN.
- Defined: opcode 0100 -> JSR state. In JSR, DR=7, enaPC, regWE (R7<-PC), and ldPC, selPC=1.
  - IR[11]=1: selEAB1=0, selEAB2=3.
  - IR[11]=0 (JSRR): selEAB1=1, SR1=IR[8:6], selEAB2=0.
  - Next state FETCH0.
- Undefined: opcode 0100 is illegal -> HALT.

Test Plan:
1. rst high 2 cycles -> state=RESET, all outputs 0; next cycle FETCH0 with enaPC=ldMAR=ldPC=1, selPC=0.
2. IR=0x1042, memRDY tied 1 -> ALU state has DR=0, SR1=1, SR2=2, ALUctrl=1, enaALU=regWE=flagWE=1; back to FETCH0 after 5 cycles total.
3. IR=0x0405 with Z=1 -> BR asserts ldPC, selPC=1, selEAB2=2; repeat with Z=0, N=1 -> ldPC=0.
4. IR=0x6283 (LDR R1,R2,#3), memRDY delayed 3 cycles -> LD_MEM holds memEN for 4 cycles, ldMDR only in the ready cycle; LD_WB DR=1, regWE=1.
5. MEM_TIMEOUT=8, memRDY held 0 in ST_MEM -> HALT after 8 wait cycles, halted=1 until rst; rst mid-wait -> RESET next edge.
6. IR=0xD000 -> HALT; IR=0x4801 -> HALT without LC3_JSR_EN, JSR with DR=7, selEAB2=3, ldPC=1 with it.
